// File: rtl/kbd_pkg.sv
// Shared types and constants for the PS/2 set-2 scancode decoder and console logic.
// Defines the fetch FSM states, prefix/modifier scancodes and the key event record.
// Also provides the receiver control-response classifier used to discard non-key bytes.
package kbd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    POP    = 2'd1,
    SETTLE = 2'd2,
    DECODE = 2'd3
  } kbd_state_t;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_RSHIFT = 8'h59;
  localparam logic [7:0] PS2_CAPS   = 8'h58;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
    logic [7:0] ascii;
  } kbd_evt_t;

  // Keyboard-to-host control responses (error, BAT, echo, ack, resend); never key codes.
  function automatic logic is_ctrl_resp(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: is_ctrl_resp = 1'b1;
      default:                                         is_ctrl_resp = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/kbd_ascii_rom.sv
// Combinational set-2 scancode to ASCII table (letters, digits, space, enter, backspace).
// Latency: zero cycles, purely combinational.
// No flow control; callers gate the result for extended/break codes themselves.
module kbd_ascii_rom
  import kbd_pkg::*;
(
  input  logic [7:0] i_code,
  input  logic       i_shift,
  input  logic       i_caps,
  output logic [7:0] o_ascii
);

  logic [7:0] w_letter;
  logic [7:0] w_digit;
  logic [7:0] w_digit_sh;

  // Look up the lowercase letter or the plain/shifted digit pair for the code.
  always_comb begin
    w_letter   = 8'h00;
    w_digit    = 8'h00;
    w_digit_sh = 8'h00;
    case (i_code)
      8'h1C: w_letter = 8'h61;
      8'h32: w_letter = 8'h62;
      8'h21: w_letter = 8'h63;
      8'h23: w_letter = 8'h64;
      8'h24: w_letter = 8'h65;
      8'h2B: w_letter = 8'h66;
      8'h34: w_letter = 8'h67;
      8'h33: w_letter = 8'h68;
      8'h43: w_letter = 8'h69;
      8'h3B: w_letter = 8'h6A;
      8'h42: w_letter = 8'h6B;
      8'h4B: w_letter = 8'h6C;
      8'h3A: w_letter = 8'h6D;
      8'h31: w_letter = 8'h6E;
      8'h44: w_letter = 8'h6F;
      8'h4D: w_letter = 8'h70;
      8'h15: w_letter = 8'h71;
      8'h2D: w_letter = 8'h72;
      8'h1B: w_letter = 8'h73;
      8'h2C: w_letter = 8'h74;
      8'h3C: w_letter = 8'h75;
      8'h2A: w_letter = 8'h76;
      8'h1D: w_letter = 8'h77;
      8'h22: w_letter = 8'h78;
      8'h35: w_letter = 8'h79;
      8'h1A: w_letter = 8'h7A;
      8'h45: begin w_digit = 8'h30; w_digit_sh = 8'h29; end
      8'h16: begin w_digit = 8'h31; w_digit_sh = 8'h21; end
      8'h1E: begin w_digit = 8'h32; w_digit_sh = 8'h40; end
      8'h26: begin w_digit = 8'h33; w_digit_sh = 8'h23; end
      8'h25: begin w_digit = 8'h34; w_digit_sh = 8'h24; end
      8'h2E: begin w_digit = 8'h35; w_digit_sh = 8'h25; end
      8'h36: begin w_digit = 8'h36; w_digit_sh = 8'h5E; end
      8'h3D: begin w_digit = 8'h37; w_digit_sh = 8'h26; end
      8'h3E: begin w_digit = 8'h38; w_digit_sh = 8'h2A; end
      8'h46: begin w_digit = 8'h39; w_digit_sh = 8'h28; end
      default: ;
    endcase
  end

  // Apply case folding to letters, shift to digits, and map the few control keys.
  always_comb begin
    o_ascii = 8'h00;
    if (w_letter != 8'h00) begin
      o_ascii = (i_shift ^ i_caps) ? (w_letter - 8'h20) : w_letter;
    end else if (w_digit != 8'h00) begin
      o_ascii = i_shift ? w_digit_sh : w_digit;
    end else begin
      case (i_code)
        8'h29:   o_ascii = 8'h20;
        8'h5A:   o_ascii = 8'h0D;
        8'h66:   o_ascii = 8'h08;
        default: o_ascii = 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Pops PS/2 set-2 bytes from the receiver FIFO, folds E0/F0 prefixes into key events with ASCII.
// Latency: SETTLE_CYC+3 cycles from kb_ready to evt_valid for a bare make code.
// Backpressure: a held event blocks further pops, nothing is dropped; KBD_REPEAT_FILTER_EN drops typematic repeats.
module ps2_scancode_decoder
  import kbd_pkg::*;
#(
  parameter int SETTLE_CYC = 4,
  parameter int CNT_W      = 8
)(
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       kb_data,
  input  logic             kb_ready,
  output logic             kb_nextdata_n,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_code,
  output logic             evt_ext,
  output logic             evt_break,
  output logic [7:0]       evt_ascii,
  output logic             shift_held,
  output logic             caps_lock,
  output logic [CNT_W-1:0] press_count
);

  localparam int SC_W = $clog2(SETTLE_CYC + 1);

  kbd_state_t       r_state;
  kbd_state_t       w_state_nxt;
  logic [SC_W-1:0]  r_settle_cnt;
  logic [7:0]       r_byte;
  logic             r_nextdata_n;
  logic             r_ext_p;
  logic             r_brk_p;
  kbd_evt_t         r_evt;
  logic             r_evt_vld;
  logic             r_lshift;
  logic             r_rshift;
  logic             r_caps;
  logic [CNT_W-1:0] r_press_cnt;

  logic             w_fetch;
  logic             w_decode;
  logic             w_is_ext;
  logic             w_is_brk;
  logic             w_is_key;
  logic             w_suppress;
  logic             w_emit;
  logic             w_mod;
  logic             w_shift_held;
  logic [7:0]       w_rom_ascii;
  logic [8:0]       w_key;

  assign w_shift_held = r_lshift | r_rshift;
  assign w_key        = {r_ext_p, r_byte};

  // Next-state logic; fetch only when the event slot is empty.
  always_comb begin
    w_state_nxt = r_state;
    w_fetch     = 1'b0;
    w_decode    = 1'b0;
    case (r_state)
      IDLE: begin
        if (kb_ready && !r_evt_vld) begin
          w_fetch     = 1'b1;
          w_state_nxt = POP;
        end
      end
      POP:    w_state_nxt = SETTLE;
      SETTLE: begin
        if (r_settle_cnt == SC_W'(SETTLE_CYC - 1)) w_state_nxt = DECODE;
      end
      DECODE: begin
        w_decode    = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register and settle counter; the counter restarts on every SETTLE entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_settle_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_settle_cnt <= (r_state == SETTLE) ? r_settle_cnt + SC_W'(1) : '0;
    end
  end

  // Latch the FIFO head and pulse nextdata_n low for the single POP cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_byte       <= 8'h00;
      r_nextdata_n <= 1'b1;
    end else begin
      r_nextdata_n <= !w_fetch;
      if (w_fetch) r_byte <= kb_data;
    end
  end

  // Classify the latched byte.
  assign w_is_ext = (r_byte == PS2_EXT);
  assign w_is_brk = (r_byte == PS2_BRK);
  assign w_is_key = !w_is_ext && !w_is_brk && !is_ctrl_resp(r_byte);

`ifdef KBD_REPEAT_FILTER_EN
  logic       r_last_vld;
  logic [8:0] r_last_key;
  logic       w_last_hit;

  assign w_last_hit = r_last_vld && (r_last_key == w_key);
  assign w_suppress = w_is_key && !r_brk_p && w_last_hit;

  // Remember the held key; its release forgets it, any other press replaces it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_vld <= 1'b0;
      r_last_key <= '0;
    end else if (w_decode && w_is_key) begin
      if (r_brk_p) begin
        if (w_last_hit) r_last_vld <= 1'b0;
      end else if (!w_last_hit) begin
        r_last_vld <= 1'b1;
        r_last_key <= w_key;
      end
    end
  end
`else
  assign w_suppress = 1'b0;
`endif

  assign w_emit = w_decode && w_is_key && !w_suppress;
  assign w_mod  = w_emit && !r_ext_p;

  kbd_ascii_rom u_ascii_rom (
    .i_code  (r_byte),
    .i_shift (w_shift_held),
    .i_caps  (r_caps),
    .o_ascii (w_rom_ascii)
  );

  // Prefix flags accumulate over E0/F0 in any order and clear on any other byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ext_p <= 1'b0;
      r_brk_p <= 1'b0;
    end else if (w_decode) begin
      if (w_is_ext) begin
        r_ext_p <= 1'b1;
      end else if (w_is_brk) begin
        r_brk_p <= 1'b1;
      end else begin
        r_ext_p <= 1'b0;
        r_brk_p <= 1'b0;
      end
    end
  end

  // Event register: loaded in DECODE, held until accepted by the consumer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_evt     <= '0;
      r_evt_vld <= 1'b0;
    end else if (w_emit) begin
      r_evt.ext   <= r_ext_p;
      r_evt.brk   <= r_brk_p;
      r_evt.code  <= r_byte;
      r_evt.ascii <= (r_ext_p || r_brk_p) ? 8'h00 : w_rom_ascii;
      r_evt_vld   <= 1'b1;
    end else if (r_evt_vld && evt_ready) begin
      r_evt_vld <= 1'b0;
    end
  end

  // Modifier tracking from non-extended emitted codes; ASCII above sees the old state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lshift <= 1'b0;
      r_rshift <= 1'b0;
      r_caps   <= 1'b0;
    end else if (w_mod) begin
      if (r_byte == PS2_LSHIFT) r_lshift <= !r_brk_p;
      if (r_byte == PS2_RSHIFT) r_rshift <= !r_brk_p;
      if (r_byte == PS2_CAPS && !r_brk_p) r_caps <= !r_caps;
    end
  end

  // Count emitted press events, wrapping naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_press_cnt <= '0;
    end else if (w_emit && !r_brk_p) begin
      r_press_cnt <= r_press_cnt + CNT_W'(1);
    end
  end

  assign kb_nextdata_n = r_nextdata_n;
  assign evt_valid     = r_evt_vld;
  assign evt_code      = r_evt.code;
  assign evt_ext       = r_evt.ext;
  assign evt_break     = r_evt.brk;
  assign evt_ascii     = r_evt.ascii;
  assign shift_held    = w_shift_held;
  assign caps_lock     = r_caps;
  assign press_count   = r_press_cnt;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder with a receiver FIFO model and event scoreboard.
// Expected events are queued as bytes are offered and checked on each accepted event.
// Expectations follow KBD_REPEAT_FILTER_EN when it is defined for the build.
module tb_ps2_scancode_decoder;
  import kbd_pkg::*;

  localparam int SETTLE_CYC = 4;
  localparam int CNT_W      = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [7:0]       kb_data = 8'h00;
  logic             kb_ready = 1'b0;
  logic             kb_nextdata_n;
  logic             evt_valid;
  logic             evt_ready = 1'b1;
  logic [7:0]       evt_code;
  logic             evt_ext;
  logic             evt_break;
  logic [7:0]       evt_ascii;
  logic             shift_held;
  logic             caps_lock;
  logic [CNT_W-1:0] press_count;

  ps2_scancode_decoder #(.SETTLE_CYC(SETTLE_CYC), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .kb_data       (kb_data),
    .kb_ready      (kb_ready),
    .kb_nextdata_n (kb_nextdata_n),
    .evt_valid     (evt_valid),
    .evt_ready     (evt_ready),
    .evt_code      (evt_code),
    .evt_ext       (evt_ext),
    .evt_break     (evt_break),
    .evt_ascii     (evt_ascii),
    .shift_held    (shift_held),
    .caps_lock     (caps_lock),
    .press_count   (press_count)
  );

  always #5 clk = ~clk;

  logic [7:0] rx_q[$];
  kbd_evt_t   exp_q[$];
  int         n_cmp   = 0;
  int         n_err   = 0;
  int         n_pulse = 0;
  int         exp_cnt = 0;
  logic       prev_n  = 1'b1;

  // Receiver FIFO model: pops on a rising edge of nextdata_n, counts low pulses.
  always @(negedge clk) begin
    if (!kb_nextdata_n && prev_n) n_pulse++;
    if (kb_nextdata_n && !prev_n && rx_q.size() != 0) void'(rx_q.pop_front());
    prev_n   = kb_nextdata_n;
    kb_ready = (rx_q.size() != 0);
    if (rx_q.size() != 0) kb_data = rx_q[0];
    else                  kb_data = 8'h00;
  end

  kbd_evt_t cur;
  kbd_evt_t held;
  kbd_evt_t exp_e;
  logic     held_v = 1'b0;

  // Scoreboard: compare each accepted event, and check held events stay stable.
  always @(negedge clk) begin
    cur.ext   = evt_ext;
    cur.brk   = evt_break;
    cur.code  = evt_code;
    cur.ascii = evt_ascii;
    if (!reset && evt_valid) begin
      if (held_v) begin
        n_cmp++;
        assert (cur === held) else begin
          n_err++;
          $error("FAIL hold_stable: observed %h required %h", cur, held);
        end
      end
      if (evt_ready) begin
        n_cmp++;
        assert (exp_q.size() != 0) else begin
          n_err++;
          $error("FAIL unexpected_evt: observed %h required none", cur);
        end
        if (exp_q.size() != 0) begin
          exp_e = exp_q.pop_front();
          n_cmp++;
          assert (cur === exp_e) else begin
            n_err++;
            $error("FAIL evt_fields: observed %h required %h", cur, exp_e);
          end
        end
        held_v = 1'b0;
      end else begin
        held   = cur;
        held_v = 1'b1;
      end
    end else begin
      held_v = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_cmp++;
    assert (obs === req) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, req);
    end
  endtask

  task automatic push_b(input logic [7:0] b);
    rx_q.push_back(b);
  endtask

  task automatic expect_evt(input logic ext, input logic brk, input logic [7:0] code,
                            input logic [7:0] ascii);
    kbd_evt_t e;
    e.ext = ext; e.brk = brk; e.code = code; e.ascii = ascii;
    exp_q.push_back(e);
    if (!brk) exp_cnt++;
  endtask

  // Wait until the FIFO, the scoreboard and the event port have all been quiet for a while.
  task automatic drain(input string tag, input int budget);
    int   stable = 0;
    logic done   = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk); #1;
      if (rx_q.size() == 0 && exp_q.size() == 0 && !evt_valid) stable++;
      else                                                      stable = 0;
      if (stable >= 12) done = 1'b1;
    end
    chk({"drain_", tag}, 32'(done), 32'd1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: observed no completion required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0;
    int lat;
    int n_wrap;

    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk); #1;
    chk("rst_nextdata_n", 32'(kb_nextdata_n), 32'd1);
    chk("rst_evt_valid", 32'(evt_valid), 32'd0);
    chk("rst_fields", {14'd0, evt_ext, evt_break, evt_code, evt_ascii}, 32'd0);
    chk("rst_mods", {30'd0, shift_held, caps_lock}, 32'd0);
    chk("rst_count", 32'(press_count), 32'd0);

    // Make then break of 'a', with first-event latency.
    p0 = n_pulse;
    @(posedge clk); #1;
    push_b(8'h1C); push_b(8'hF0); push_b(8'h1C);
    expect_evt(1'b0, 1'b0, 8'h1C, 8'h61);
    expect_evt(1'b0, 1'b1, 8'h1C, 8'h00);
    for (int i = 0; i < 5 && !kb_ready; i++) begin @(negedge clk); #1; end
    lat = 0;
    for (int i = 0; i < 40 && !evt_valid; i++) begin @(negedge clk); #1; lat++; end
    chk("latency", lat, SETTLE_CYC + 3);
    drain("t1", 200);
    chk("t1_count", 32'(press_count), 32'(exp_cnt));
    chk("t1_pulses", n_pulse - p0, 3);

    // Shifted letter.
    push_b(8'h12);
    expect_evt(1'b0, 1'b0, 8'h12, 8'h00);
    drain("t2a", 200);
    chk("t2_shift_on", 32'(shift_held), 32'd1);
    push_b(8'h1C); push_b(8'hF0); push_b(8'h1C); push_b(8'hF0); push_b(8'h12);
    expect_evt(1'b0, 1'b0, 8'h1C, 8'h41);
    expect_evt(1'b0, 1'b1, 8'h1C, 8'h00);
    expect_evt(1'b0, 1'b1, 8'h12, 8'h00);
    drain("t2b", 300);
    chk("t2_shift_off", 32'(shift_held), 32'd0);
    chk("t2_count", 32'(press_count), 32'(exp_cnt));

    // Extended key press/release in both prefix orders.
    push_b(8'hE0); push_b(8'h75);
    push_b(8'hE0); push_b(8'hF0); push_b(8'h75);
    push_b(8'hF0); push_b(8'hE0); push_b(8'h75);
    expect_evt(1'b1, 1'b0, 8'h75, 8'h00);
    expect_evt(1'b1, 1'b1, 8'h75, 8'h00);
    expect_evt(1'b1, 1'b1, 8'h75, 8'h00);
    drain("t3", 400);
    chk("t3_count", 32'(press_count), 32'(exp_cnt));

    // Backpressure: one event held, no further pops.
    @(posedge clk); #2 evt_ready = 1'b0;
    p0 = n_pulse;
    push_b(8'h1C); push_b(8'h32); push_b(8'h21);
    expect_evt(1'b0, 1'b0, 8'h1C, 8'h61);
    expect_evt(1'b0, 1'b0, 8'h32, 8'h62);
    expect_evt(1'b0, 1'b0, 8'h21, 8'h63);
    repeat (60) @(negedge clk);
    #1;
    chk("bp_valid", 32'(evt_valid), 32'd1);
    chk("bp_code", 32'(evt_code), 32'h1C);
    chk("bp_pulses", n_pulse - p0, 1);
    chk("bp_fifo_left", rx_q.size(), 2);
    @(posedge clk); #2 evt_ready = 1'b1;
    drain("t4", 300);
    chk("t4_pulses", n_pulse - p0, 3);
    chk("t4_count", 32'(press_count), 32'(exp_cnt));

    // Typematic repeats and caps lock.
    push_b(8'h1C); push_b(8'h1C); push_b(8'h1C); push_b(8'hF0); push_b(8'h1C);
    push_b(8'h58); push_b(8'h58); push_b(8'hF0); push_b(8'h58);
    expect_evt(1'b0, 1'b0, 8'h1C, 8'h61);
`ifndef KBD_REPEAT_FILTER_EN
    expect_evt(1'b0, 1'b0, 8'h1C, 8'h61);
    expect_evt(1'b0, 1'b0, 8'h1C, 8'h61);
`endif
    expect_evt(1'b0, 1'b1, 8'h1C, 8'h00);
    expect_evt(1'b0, 1'b0, 8'h58, 8'h00);
`ifndef KBD_REPEAT_FILTER_EN
    expect_evt(1'b0, 1'b0, 8'h58, 8'h00);
`endif
    expect_evt(1'b0, 1'b1, 8'h58, 8'h00);
    drain("t5", 600);
`ifdef KBD_REPEAT_FILTER_EN
    chk("t5_caps", 32'(caps_lock), 32'd1);
`else
    chk("t5_caps", 32'(caps_lock), 32'd0);
`endif
    chk("t5_count", 32'(press_count), 32'(exp_cnt));

    // Reset during SETTLE after an E0 prefix and the following pop.
    p0 = n_pulse;
    push_b(8'hE0); push_b(8'h1C);
    for (int i = 0; i < 60 && (n_pulse - p0) < 2; i++) begin @(negedge clk); #1; end
    chk("rst_pop_seen", n_pulse - p0, 2);
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #2;
    @(posedge clk); #2 reset = 1'b0;
    exp_cnt = 0;
    @(negedge clk); #1;
    chk("mid_rst_nextdata_n", 32'(kb_nextdata_n), 32'd1);
    chk("mid_rst_fields", {13'd0, evt_valid, evt_ext, evt_break, evt_code, evt_ascii}, 32'd0);
    chk("mid_rst_mods", {30'd0, shift_held, caps_lock}, 32'd0);
    chk("mid_rst_count", 32'(press_count), 32'd0);
    repeat (20) @(negedge clk);
    #1;
    chk("no_evt_after_rst", 32'(evt_valid), 32'd0);
    push_b(8'h24);
    expect_evt(1'b0, 1'b0, 8'h24, 8'h65);
    drain("t6a", 200);

    // Control responses are dropped and cancel a pending prefix.
    p0 = n_pulse;
    push_b(8'hAA);
    drain("t6b", 200);
    chk("aa_pulse", n_pulse - p0, 1);
    push_b(8'hE0); push_b(8'hAA); push_b(8'h1C);
    expect_evt(1'b0, 1'b0, 8'h1C, 8'h61);
    drain("t6c", 300);
    chk("t6_count", 32'(press_count), 32'(exp_cnt));

    // Shifted digit and space; caps combined with shift.
    push_b(8'h12); push_b(8'h1E); push_b(8'hF0); push_b(8'h12); push_b(8'h29);
    expect_evt(1'b0, 1'b0, 8'h12, 8'h00);
    expect_evt(1'b0, 1'b0, 8'h1E, 8'h40);
    expect_evt(1'b0, 1'b1, 8'h12, 8'h00);
    expect_evt(1'b0, 1'b0, 8'h29, 8'h20);
    push_b(8'h58); push_b(8'h1C); push_b(8'h12); push_b(8'h1C); push_b(8'hF0); push_b(8'h12);
    push_b(8'h58);
    expect_evt(1'b0, 1'b0, 8'h58, 8'h00);
    expect_evt(1'b0, 1'b0, 8'h1C, 8'h41);
    expect_evt(1'b0, 1'b0, 8'h12, 8'h00);
    expect_evt(1'b0, 1'b0, 8'h1C, 8'h61);
    expect_evt(1'b0, 1'b1, 8'h12, 8'h00);
    expect_evt(1'b0, 1'b0, 8'h58, 8'h00);
    drain("t7", 600);
    chk("t7_caps", 32'(caps_lock), 32'd0);
    chk("t7_count", 32'(press_count), 32'(exp_cnt));

    // press_count wraps from all-ones to zero.
    n_wrap = (1 << CNT_W) - exp_cnt;
    for (int i = 0; i < n_wrap; i++) begin
      if (i % 2 == 0) begin push_b(8'h1C); expect_evt(1'b0, 1'b0, 8'h1C, 8'h61); end
      else            begin push_b(8'h32); expect_evt(1'b0, 1'b0, 8'h32, 8'h62); end
    end
    drain("wrap", 5000);
    chk("wrap_zero", 32'(press_count), 32'd0);
    push_b(8'h21);
    expect_evt(1'b0, 1'b0, 8'h21, 8'h63);
    drain("wrap1", 200);
    chk("wrap_one", 32'(press_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
